vram_write_arbiter: RTL and testbench

Shares the single video RAM write port (11-bit address, 16-bit data) between a host write requester and a built-in fill engine. The fill engine clears or paints a linear range of character cells. The block sits in front of the VRAM write port of the 40x30 text display and runs entirely in the VRAM write clock domain. Host writes have priority, and a starvation limit guarantees the fill engine forward progress.

---
 rtl/vram_pkg.sv | 9 +
 rtl/vram_fill.sv | 64 ++++++
 rtl/vram_write_arbiter.sv | 77 +++++++
 tb/tb_vram_write_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the text-display VRAM write path.
package vram_pkg;
    localparam int VRAM_AW   = 11;
    localparam int VRAM_DW   = 16;
    localparam int TEXT_COLS = 40;
    localparam int TEXT_ROWS = 30;

    typedef enum logic {IDLE, RUN} fill_state_t;
endpackage

// File: rtl/vram_fill.sv
// Fill engine: walks a linear VRAM range writing a constant value, one word per grant.
module vram_fill import vram_pkg::*; #(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   start_count,
    input  logic [DW-1:0] start_data,
    input  logic          grant,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          last,
    output logic          busy,
    output logic          done
);
    fill_state_t   state, state_nx;
    logic [AW-1:0] cur;
    logic [AW:0]   rem;
    logic [DW-1:0] val;

    assign req  = (state == RUN);
    assign busy = (state == RUN);
    assign addr = cur;
    assign data = val;
    assign last = (rem == {{AW{1'b0}}, 1'b1});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && start_count != '0) state_nx = RUN;
            RUN:     if (grant && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cur   <= '0;
            rem   <= '0;
            val   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                cur  <= start_addr;
                rem  <= start_count;
                val  <= start_data;
                // An empty fill still completes, so callers can treat count=0 uniformly
                done <= (start_count == '0);
            end else if (state == RUN && grant) begin
                cur  <= cur + 1'b1;
                rem  <= rem - 1'b1;
                // Registered so it lines up with vram_we of the final word
                done <= last;
            end
        end
    end
endmodule

// File: rtl/vram_write_arbiter.sv
// Host-priority arbiter for the VRAM write port with a starvation-bounded fill engine.
module vram_write_arbiter import vram_pkg::*; #(
    parameter int AW     = VRAM_AW,
    parameter int DW     = VRAM_DW,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_data,
    input  logic          f_start,
    input  logic [AW-1:0] f_addr,
    input  logic [AW:0]   f_count,
    input  logic [DW-1:0] f_data,
    output logic          f_busy,
    output logic          f_done,
    output logic [AW-1:0] vram_waddr,
    output logic [DW-1:0] vram_wdata,
    output logic          vram_we
);
    logic          fill_req, fill_last, fill_gnt, host_gnt;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic [3:0]    starve_cnt;
    logic          starved;

    vram_fill #(.AW(AW), .DW(DW)) u_fill (
        .clk         (clk),
        .reset       (reset),
        .start       (f_start),
        .start_addr  (f_addr),
        .start_count (f_count),
        .start_data  (f_data),
        .grant       (fill_gnt),
        .req         (fill_req),
        .addr        (fill_addr),
        .data        (fill_data),
        .last        (fill_last),
        .busy        (f_busy),
        .done        (f_done)
    );

    // h_ready comes only from registered state so the host never sees a comb loop
    assign starved  = fill_req && (starve_cnt == 4'(STARVE));
    assign h_ready  = !starved;
    assign host_gnt = h_valid && h_ready;
    assign fill_gnt = fill_req && !host_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!fill_req || fill_gnt) begin
            starve_cnt <= '0;
        end else if (host_gnt && starve_cnt != 4'(STARVE)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            vram_we <= host_gnt || fill_gnt;
            if (host_gnt) begin
                vram_waddr <= h_addr;
                vram_wdata <= h_data;
            end else if (fill_gnt) begin
                vram_waddr <= fill_addr;
                vram_wdata <= fill_data;
            end
        end
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: host, fill, contention, wrap, zero count, reset.
module tb_vram_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        h_valid;
    logic        h_ready;
    logic [10:0] h_addr;
    logic [15:0] h_data;
    logic        f_start;
    logic [10:0] f_addr;
    logic [11:0] f_count;
    logic [15:0] f_data;
    logic        f_busy;
    logic        f_done;
    logic [10:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_we;

    int checks = 0;
    int errors = 0;

    logic [10:0] wa[$];
    logic [15:0] wd[$];
    int          done_cnt;
    int          busy_cnt;

    vram_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_addr     (h_addr),
        .h_data     (h_data),
        .f_start    (f_start),
        .f_addr     (f_addr),
        .f_count    (f_count),
        .f_data     (f_data),
        .f_busy     (f_busy),
        .f_done     (f_done),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input int n);
        wa.delete();
        wd.delete();
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (vram_we) begin
                wa.push_back(vram_waddr);
                wd.push_back(vram_wdata);
            end
            if (f_done) done_cnt++;
            if (f_busy) busy_cnt++;
        end
    endtask

    initial begin
        int          we_c, busy_c, done_c, bad, first_we, last_we, seen;
        logic [10:0] exp_a, done_addr;

        reset = 1'b1; h_valid = 1'b0; h_addr = '0; h_data = '0;
        f_start = 1'b0; f_addr = '0; f_count = '0; f_data = '0;
        tick(); tick();
        chk("rst_we", vram_we, 0);
        chk("rst_waddr", vram_waddr, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_busy", f_busy, 0);
        chk("rst_done", f_done, 0);
        chk("rst_hready", h_ready, 1);
        reset = 1'b0;
        tick();

        // host only
        h_valid = 1'b1; h_addr = 11'h010; h_data = 16'hAAAA;
        chk("h0_ready", h_ready, 1);
        tick();
        chk("h0_we", vram_we, 1); chk("h0_a", vram_waddr, 11'h010); chk("h0_d", vram_wdata, 16'hAAAA);
        h_addr = 11'h011; h_data = 16'h5555;
        chk("h1_ready", h_ready, 1);
        tick();
        chk("h1_we", vram_we, 1); chk("h1_a", vram_waddr, 11'h011); chk("h1_d", vram_wdata, 16'h5555);
        h_addr = 11'h7FF; h_data = 16'h1234;
        chk("h2_ready", h_ready, 1);
        tick();
        chk("h2_we", vram_we, 1); chk("h2_a", vram_waddr, 11'h7FF); chk("h2_d", vram_wdata, 16'h1234);
        h_valid = 1'b0;
        tick();
        chk("h_idle_we", vram_we, 0);
        chk("h_hold_a", vram_waddr, 11'h7FF);
        chk("h_hold_d", vram_wdata, 16'h1234);

        // fill only, 1200 words from 0
        f_start = 1'b1; f_addr = 11'h000; f_count = 12'd1200; f_data = 16'h0020;
        we_c = 0; busy_c = 0; done_c = 0; bad = 0; first_we = -1; last_we = -1;
        exp_a = 11'h000; done_addr = '0;
        for (int i = 0; i < 1210; i++) begin
            tick();
            if (i == 0) begin
                f_start = 1'b0;
                chk("f_busy_n1", f_busy, 1);
                chk("f_we_n1", vram_we, 0);
            end
            if (f_busy) busy_c++;
            if (vram_we) begin
                if (vram_waddr !== exp_a || vram_wdata !== 16'h0020) bad++;
                exp_a = exp_a + 11'd1;
                we_c++;
                if (first_we < 0) first_we = i;
                last_we = i;
            end
            if (f_done) begin
                done_c++;
                done_addr = vram_waddr;
            end
        end
        chk("fill_we_cnt", we_c, 1200);
        chk("fill_contig", last_we - first_we + 1, 1200);
        chk("fill_first_we", first_we, 1);
        chk("fill_addr_bad", bad, 0);
        chk("fill_busy_cnt", busy_c, 1200);
        chk("fill_done_cnt", done_c, 1);
        chk("fill_done_addr", done_addr, 11'h4AF);

        // contention: STARVE=4, count 3, host held high
        f_start = 1'b1; f_addr = 11'h200; f_count = 12'd3; f_data = 16'h0F0F;
        tick();
        f_start = 1'b0;
        h_valid = 1'b1; h_addr = 11'h100; h_data = 16'hBEEF;
        for (int i = 0; i < 15; i++) begin
            logic is_f;
            is_f = (i % 5 == 4);
            chk($sformatf("ct_ready%0d", i), h_ready, !is_f);
            tick();
            chk($sformatf("ct_we%0d", i), vram_we, 1);
            chk($sformatf("ct_a%0d", i), vram_waddr, is_f ? 11'h200 + 11'(i / 5) : 11'h100);
            chk($sformatf("ct_d%0d", i), vram_wdata, is_f ? 16'h0F0F : 16'hBEEF);
            chk($sformatf("ct_done%0d", i), f_done, i == 14);
        end
        chk("ct_busy_end", f_busy, 0);
        chk("ct_ready_end", h_ready, 1);
        h_valid = 1'b0;
        tick();

        // wrap around the top of the address space
        f_start = 1'b1; f_addr = 11'h7FE; f_count = 12'd4; f_data = 16'h00C3;
        tick();
        f_start = 1'b0;
        collect(8);
        chk("wrap_cnt", wa.size(), 4);
        chk("wrap_done", done_cnt, 1);
        if (wa.size() == 4) begin
            chk("wrap_a0", wa[0], 11'h7FE);
            chk("wrap_a1", wa[1], 11'h7FF);
            chk("wrap_a2", wa[2], 11'h000);
            chk("wrap_a3", wa[3], 11'h001);
            chk("wrap_d3", wd[3], 16'h00C3);
        end

        // zero count
        f_start = 1'b1; f_addr = 11'h123; f_count = 12'd0; f_data = 16'hFFFF;
        tick();
        f_start = 1'b0;
        chk("z_done", f_done, 1);
        chk("z_busy", f_busy, 0);
        chk("z_we", vram_we, 0);
        collect(4);
        chk("z_writes", wa.size(), 0);
        chk("z_done_after", done_cnt, 0);
        chk("z_busy_after", busy_cnt, 0);

        // start during RUN is ignored
        f_start = 1'b1; f_addr = 11'h300; f_count = 12'd5; f_data = 16'h1111;
        tick();
        f_addr = 11'h000; f_count = 12'd2; f_data = 16'h2222;
        wa.delete();
        collect(1);
        f_start = 1'b0;
        begin
            logic [10:0] a0;
            int          n0, d0;
            n0 = wa.size();
            a0 = (n0 > 0) ? wa[0] : 11'h7FF;
            d0 = done_cnt;
            collect(10);
            chk("ign_cnt", n0 + wa.size(), 5);
            chk("ign_a0", a0, 11'h300);
            chk("ign_done", d0 + done_cnt, 1);
            if (wa.size() == 4) begin
                chk("ign_a4", wa[3], 11'h304);
                chk("ign_d4", wd[3], 16'h1111);
            end
        end

        // reset mid-fill
        f_start = 1'b1; f_addr = 11'h000; f_count = 12'd1200; f_data = 16'h0020;
        seen = 0;
        for (int i = 0; i < 300 && seen < 100; i++) begin
            tick();
            if (i == 0) f_start = 1'b0;
            if (vram_we) seen++;
        end
        chk("rm_wait", seen, 100);
        reset = 1'b1;
        tick();
        chk("rm_we", vram_we, 0);
        chk("rm_busy", f_busy, 0);
        chk("rm_done", f_done, 0);
        reset = 1'b0;
        collect(3);
        chk("rm_no_done", done_cnt, 0);
        chk("rm_no_we", wa.size(), 0);
        f_start = 1'b1; f_addr = 11'h050; f_count = 12'd2; f_data = 16'h7777;
        tick();
        f_start = 1'b0;
        chk("rm2_busy", f_busy, 1);
        collect(6);
        chk("rm2_cnt", wa.size(), 2);
        chk("rm2_done", done_cnt, 1);
        if (wa.size() == 2) begin
            chk("rm2_a0", wa[0], 11'h050);
            chk("rm2_a1", wa[1], 11'h051);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
